// File: rtl/alarm_pkg.sv
// Shared types and default timing constants for the alarm buzzer sequencer.
// Defaults are derived from the 31.5 MHz video clock.
package alarm_pkg;

   typedef enum logic [1:0] {
      OFF     = 2'd0,
      ARMED   = 2'd1,
      RINGING = 2'd2,
      SNOOZE  = 2'd3
   } alarm_state_e;

   localparam int CLK_HZ  = 31_500_000;
   localparam int TONE_HZ = 3_150;

   localparam int TONE_HALF_DEF      = CLK_HZ / (2 * TONE_HZ);
   localparam int CADENCE_ON_DEF     = CLK_HZ / 2;
   localparam int SNOOZE_S_DEF       = 300;
   localparam int RING_TIMEOUT_S_DEF = 60;

   localparam int HOUR_W    = 4;
   localparam int MIN_W     = 6;
   localparam int TIMEOUT_W = 6;
   localparam int SNOOZE_W  = 9;
   localparam int CAD_W     = 24;
   localparam int TONE_W    = 13;

endpackage

// File: rtl/alarm_sequencer_if.sv
// Time/alarm registers, button pulses and alarm status between the clock top
// (master) and the alarm sequencer (slave).
interface alarm_sequencer_if;
   import alarm_pkg::*;

   logic              sec_tick;
   logic [HOUR_W-1:0] hours;
   logic [MIN_W-1:0]  minutes;
   logic [HOUR_W-1:0] al_hours;
   logic [MIN_W-1:0]  al_minutes;
   logic              toggle_pulse;
   logic              snooze_pulse;
   logic              buzzer_out;
   logic              al_on;
   logic              ringing;
   logic              snoozing;

   modport master (
      output sec_tick, hours, minutes, al_hours, al_minutes,
             toggle_pulse, snooze_pulse,
      input  buzzer_out, al_on, ringing, snoozing
   );

   modport slave (
      input  sec_tick, hours, minutes, al_hours, al_minutes,
             toggle_pulse, snooze_pulse,
      output buzzer_out, al_on, ringing, snoozing
   );

endinterface

// File: rtl/buzzer_pattern_gen.sv
// Square-wave tone gated by a per-second cadence window. pattern_o reflects the
// values the registers are about to take, so the caller can register it alongside.
module buzzer_pattern_gen
   import alarm_pkg::*;
#(
   parameter int TONE_HALF  = TONE_HALF_DEF,
   parameter int CADENCE_ON = CADENCE_ON_DEF
) (
   input  logic video_clk,
   input  logic reset,
   input  logic enable_i,
   input  logic restart_i,
   input  logic sec_tick_i,
   output logic pattern_o
);

   localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(TONE_HALF - 1);
   localparam logic [CAD_W-1:0]  CAD_LIM   = CAD_W'(CADENCE_ON);

   logic              tone_q, tone_d;
   logic [TONE_W-1:0] tone_cnt_q, tone_cnt_d;
   logic [CAD_W-1:0]  cad_cnt_q, cad_cnt_d;

   always_comb begin
      tone_d     = tone_q;
      tone_cnt_d = tone_cnt_q;
      cad_cnt_d  = cad_cnt_q;
      if (restart_i) begin
         tone_d     = 1'b1;
         tone_cnt_d = '0;
         cad_cnt_d  = '0;
      end else if (enable_i) begin
         if (tone_cnt_q >= TONE_LAST) begin
            tone_cnt_d = '0;
            tone_d     = ~tone_q;
         end else begin
            tone_cnt_d = tone_cnt_q + TONE_W'(1);
         end
         // Cadence window reopens every second, then holds closed at the limit.
         if (sec_tick_i) begin
            cad_cnt_d = '0;
         end else if (cad_cnt_q < CAD_LIM) begin
            cad_cnt_d = cad_cnt_q + CAD_W'(1);
         end
      end
   end

   assign pattern_o = tone_d & (cad_cnt_d < CAD_LIM);

   always_ff @(posedge video_clk) begin
      if (reset) begin
         tone_q     <= 1'b0;
         tone_cnt_q <= '0;
         cad_cnt_q  <= '0;
      end else begin
         tone_q     <= tone_d;
         tone_cnt_q <= tone_cnt_d;
         cad_cnt_q  <= cad_cnt_d;
      end
   end

endmodule

// File: rtl/alarm_sequencer.sv
// Alarm arm/ring/snooze/timeout state machine for the 12-hour VGA clock.
// All status outputs and the buzzer are registered from the next state.
module alarm_sequencer
   import alarm_pkg::*;
#(
   parameter int TONE_HALF      = TONE_HALF_DEF,
   parameter int CADENCE_ON     = CADENCE_ON_DEF,
   parameter int SNOOZE_S       = SNOOZE_S_DEF,
   parameter int RING_TIMEOUT_S = RING_TIMEOUT_S_DEF
) (
   input logic               video_clk,
   input logic               reset,
   alarm_sequencer_if.slave  bus
);

   localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(RING_TIMEOUT_S - 1);
   localparam logic [SNOOZE_W-1:0]  SNOOZE_LOAD  = SNOOZE_W'(SNOOZE_S);

   alarm_state_e         state_q, state_d;
   logic                 eq, eq_q, match;
   logic [TIMEOUT_W-1:0] timeout_q, timeout_d;
   logic [SNOOZE_W-1:0]  snooze_q, snooze_d;
   logic                 ring_d, ring_entry, pattern;
   logic                 buzzer_q, al_on_q, ringing_q, snoozing_q;

   assign eq    = (bus.hours == bus.al_hours) && (bus.minutes == bus.al_minutes);
   assign match = eq & ~eq_q;

   always_comb begin
      state_d   = state_q;
      timeout_d = timeout_q;
      snooze_d  = snooze_q;
      if (bus.toggle_pulse) begin
         state_d = (state_q == OFF) ? ARMED : OFF;
      end else begin
         case (state_q)
            ARMED: begin
               if (match) state_d = RINGING;
            end
            RINGING: begin
               if (bus.snooze_pulse) begin
                  state_d  = SNOOZE;
                  snooze_d = SNOOZE_LOAD;
               end else if (bus.sec_tick) begin
                  if (timeout_q >= TIMEOUT_LAST) state_d = ARMED;
                  else timeout_d = timeout_q + TIMEOUT_W'(1);
               end
            end
            SNOOZE: begin
               if (bus.sec_tick) begin
                  if (snooze_q <= SNOOZE_W'(1)) begin
                     state_d  = RINGING;
                     snooze_d = '0;
                  end else begin
                     snooze_d = snooze_q - SNOOZE_W'(1);
                  end
               end
            end
            default: ;
         endcase
      end
      // Every entry into RINGING starts a fresh unattended-ring timeout.
      if (state_d == RINGING && state_q != RINGING) timeout_d = '0;
   end

   assign ring_d     = (state_d == RINGING);
   assign ring_entry = ring_d && (state_q != RINGING);

   buzzer_pattern_gen #(
      .TONE_HALF  (TONE_HALF),
      .CADENCE_ON (CADENCE_ON)
   ) u_pattern (
      .video_clk  (video_clk),
      .reset      (reset),
      .enable_i   (ring_d),
      .restart_i  (ring_entry),
      .sec_tick_i (bus.sec_tick),
      .pattern_o  (pattern)
   );

   always_ff @(posedge video_clk) begin
      if (reset) begin
         state_q    <= OFF;
         eq_q       <= 1'b0;
         timeout_q  <= '0;
         snooze_q   <= '0;
         buzzer_q   <= 1'b0;
         al_on_q    <= 1'b0;
         ringing_q  <= 1'b0;
         snoozing_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         eq_q       <= eq;
         timeout_q  <= timeout_d;
         snooze_q   <= snooze_d;
         buzzer_q   <= ring_d & pattern;
         al_on_q    <= (state_d != OFF);
         ringing_q  <= ring_d;
         snoozing_q <= (state_d == SNOOZE);
      end
   end

   assign bus.buzzer_out = buzzer_q;
   assign bus.al_on      = al_on_q;
   assign bus.ringing    = ringing_q;
   assign bus.snoozing   = snoozing_q;

endmodule
